rc4_encrypt_fsm: RTL and testbench

//  Encrypts a MSG_LEN-byte plaintext message with RC4 under a 24-bit secret key and writes the

---
 rtl/rc4_encrypt_fsm.sv | 240 ++++++++++++++++++++++++
 tb/tb_rc4_encrypt_fsm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_encrypt_fsm.sv
// rc4_encrypt_fsm
//   Encrypts a MSG_LEN-byte plaintext with RC4 under a 24-bit key and writes
//   the ciphertext to an output RAM. The RC4 permutation lives in an external
//   256x8 S-RAM that this block initialises, scrambles (KSA) and then walks
//   (PRGA) to generate the keystream.
//
// Ports
//   clock       system clock, all logic on posedge
//   reset       synchronous active-high reset
//   start       one-cycle request, accepted only in IDLE or DONE
//   key         24-bit secret key, latched when start is accepted
//   busy        high while an encryption is in progress
//   done        high once the message is written, until the next start
//   s_address   S-RAM address
//   s_data      S-RAM write data
//   s_wren      S-RAM write enable
//   s_q         S-RAM read data (one cycle after s_address)
//   pt_address  plaintext RAM address
//   pt_q        plaintext read data (one cycle after pt_address)
//   ct_address  ciphertext RAM address
//   ct_data     ciphertext write data
//   ct_wren     ciphertext write enable
module rc4_encrypt_fsm #(
  parameter int MSG_LEN   = 32,
  parameter int KEY_BYTES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] key,
  output logic        busy,
  output logic        done,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  input  logic [7:0]  s_q,
  output logic [4:0]  pt_address,
  input  logic [7:0]  pt_q,
  output logic [4:0]  ct_address,
  output logic [7:0]  ct_data,
  output logic        ct_wren
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [4:0] {
    IDLE,
    INIT,
    KSA_RD_I,
    KSA_WT_I,
    KSA_J,
    KSA_WT_J,
    KSA_WR_I,
    KSA_WR_J,
    PRG_INC,
    PRG_WT_I,
    PRG_J,
    PRG_WT_J,
    PRG_WR_I,
    PRG_WR_J,
    PRG_RD_F,
    PRG_WT_F,
    PRG_WR_C,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [23:0]       key_q;
  logic [7:0]        i_q, j_q, si_q, sj_q, f_q, p_q;
  logic [4:0]        k_q;
  logic [KIDX_W-1:0] kidx_q;

  logic [7:0] key_byte;
  logic [7:0] j_ksa;
  logic [7:0] j_prg;
  logic [7:0] i_inc;
  logic       last_i;
  logic       last_k;
  logic       last_kidx;

  // kidx_q tracks i mod KEY_BYTES alongside i, so the key byte is a plain
  // mux rather than a divider.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx_q == KIDX_W'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  // The new j is presented to the S-RAM in the same cycle it is computed,
  // so the read data arrives in the following wait state.
  always_comb begin
    j_ksa     = j_q + si_q + key_byte;
    j_prg     = j_q + si_q;
    i_inc     = i_q + 8'd1;
    last_i    = (i_q == 8'hFF);
    last_k    = (k_q == 5'(MSG_LEN - 1));
    last_kidx = (kidx_q == KIDX_W'(KEY_BYTES - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = INIT;
      INIT:     if (last_i) state_d = KSA_RD_I;
      KSA_RD_I: state_d = KSA_WT_I;
      KSA_WT_I: state_d = KSA_J;
      KSA_J:    state_d = KSA_WT_J;
      KSA_WT_J: state_d = KSA_WR_I;
      KSA_WR_I: state_d = KSA_WR_J;
      KSA_WR_J: state_d = last_i ? PRG_INC : KSA_RD_I;
      PRG_INC:  state_d = PRG_WT_I;
      PRG_WT_I: state_d = PRG_J;
      PRG_J:    state_d = PRG_WT_J;
      PRG_WT_J: state_d = PRG_WR_I;
      PRG_WR_I: state_d = PRG_WR_J;
      PRG_WR_J: state_d = PRG_RD_F;
      PRG_RD_F: state_d = PRG_WT_F;
      PRG_WT_F: state_d = PRG_WR_C;
      PRG_WR_C: state_d = last_k ? DONE : PRG_INC;
      DONE:     if (start) state_d = INIT;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath registers. The i==255 wrap in INIT leaves i at 0 for the KSA.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_q  <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      kidx_q <= '0;
      si_q   <= '0;
      sj_q   <= '0;
      f_q    <= '0;
      p_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            key_q <= key;
            i_q   <= '0;
          end
        end
        INIT: begin
          i_q <= i_inc;
          if (last_i) begin
            j_q    <= '0;
            kidx_q <= '0;
          end
        end
        KSA_WT_I: si_q <= s_q;
        KSA_J:    j_q  <= j_ksa;
        KSA_WT_J: sj_q <= s_q;
        KSA_WR_J: begin
          if (last_i) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
          end else begin
            i_q    <= i_inc;
            kidx_q <= last_kidx ? '0 : kidx_q + KIDX_W'(1);
          end
        end
        PRG_INC:  i_q  <= i_inc;
        PRG_WT_I: si_q <= s_q;
        PRG_J:    j_q  <= j_prg;
        PRG_WT_J: sj_q <= s_q;
        PRG_WT_F: begin
          f_q <= s_q;
          p_q <= pt_q;
        end
        PRG_WR_C: if (!last_k) k_q <= k_q + 5'd1;
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the state alone, so a reset returns every
  // address, data and enable to zero on the very next cycle. Read addresses
  // are held through each wait state for RAMs that re-sample them.
  always_comb begin
    busy       = 1'b1;
    done       = 1'b0;
    s_address  = '0;
    s_data     = '0;
    s_wren     = 1'b0;
    pt_address = '0;
    ct_address = '0;
    ct_data    = '0;
    ct_wren    = 1'b0;
    unique case (state_q)
      IDLE: busy = 1'b0;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      INIT: begin
        s_address = i_q;
        s_data    = i_q;
        s_wren    = 1'b1;
      end
      KSA_RD_I, KSA_WT_I, PRG_WT_I: s_address = i_q;
      KSA_J:                        s_address = j_ksa;
      KSA_WT_J, PRG_WT_J:           s_address = j_q;
      PRG_INC:                      s_address = i_inc;
      PRG_J:                        s_address = j_prg;
      KSA_WR_I, PRG_WR_I: begin
        s_address = i_q;
        s_data    = sj_q;
        s_wren    = 1'b1;
      end
      KSA_WR_J, PRG_WR_J: begin
        // When i==j this lands on the same cell as WR_I and leaves si there,
        // which is the correct result of swapping an entry with itself.
        s_address = j_q;
        s_data    = si_q;
        s_wren    = 1'b1;
      end
      PRG_RD_F, PRG_WT_F: begin
        s_address  = si_q + sj_q;
        pt_address = k_q;
      end
      PRG_WR_C: begin
        ct_address = k_q;
        ct_data    = f_q ^ p_q;
        ct_wren    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// tb_rc4_encrypt_fsm
//   Drives rc4_encrypt_fsm against behavioural S-RAM, plaintext and
//   ciphertext RAMs and compares each ciphertext with a software RC4 model.
module tb_rc4_encrypt_fsm;

  localparam int MSG_LEN  = 32;
  localparam int LATENCY  = 256 + 256*6 + MSG_LEN*9;
  localparam int MAX_WAIT = 3000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] key   = '0;
  logic        busy, done;
  logic [7:0]  s_address, s_data, s_q;
  logic        s_wren;
  logic [4:0]  pt_address, ct_address;
  logic [7:0]  pt_q, ct_data;
  logic        ct_wren;

  logic [7:0] sram  [256];
  logic [7:0] ptram [32];
  logic [7:0] ctram [32];
  logic [4:0] ctAddrLog [$];
  int         sWrTotal = 0;
  int         ctWrTotal = 0;
  int         overlapTotal = 0;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] pt3 [MSG_LEN];
  logic [7:0] ct3 [MSG_LEN];
  logic [7:0] expCt [MSG_LEN];

  rc4_encrypt_fsm #(.MSG_LEN(MSG_LEN), .KEY_BYTES(3)) dut (
    .clock(clock), .reset(reset), .start(start), .key(key),
    .busy(busy), .done(done),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .pt_address(pt_address), .pt_q(pt_q),
    .ct_address(ct_address), .ct_data(ct_data), .ct_wren(ct_wren)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM models plus a tally of every write strobe.
  always @(posedge clock) begin
    if (s_wren) sram[s_address] <= s_data;
    s_q  <= sram[s_address];
    pt_q <= ptram[pt_address];
    if (ct_wren) begin
      ctram[ct_address] <= ct_data;
      ctAddrLog.push_back(ct_address);
    end
    if (s_wren) sWrTotal++;
    if (ct_wren) ctWrTotal++;
    if (s_wren && ct_wren) overlapTotal++;
  end

  // Textbook RC4: KSA over the 3 key bytes, then MSG_LEN keystream bytes.
  function automatic void rc4Ref(input logic [23:0] k, input logic [7:0] pt[MSG_LEN],
                                 output logic [7:0] ct[MSG_LEN]);
    logic [7:0] S [256];
    logic [7:0] tmp;
    int ii, jj, t;
    for (int n = 0; n < 256; n++) S[n] = 8'(n);
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      jj = (jj + int'(S[n]) + int'(k[23 - 8*(n % 3) -: 8])) % 256;
      tmp = S[n]; S[n] = S[jj]; S[jj] = tmp;
    end
    ii = 0;
    jj = 0;
    for (int n = 0; n < MSG_LEN; n++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(S[ii])) % 256;
      tmp = S[ii]; S[ii] = S[jj]; S[jj] = tmp;
      t = (int'(S[ii]) + int'(S[jj])) % 256;
      ct[n] = pt[n] ^ S[t];
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic startOnly(input logic [23:0] k);
    @(negedge clock);
    key   = k;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    key   = 24'($urandom);
  endtask

  // Launches one encryption and waits (bounded) for done. Optionally pulses
  // start with an all-ones key while busy, which must be ignored.
  task automatic applyStimulus(input logic [23:0] k, input bit pulseBusy, output int lat);
    startOnly(k);
    lat = 0;
    while (lat < MAX_WAIT) begin
      @(posedge clock);
      lat++;
      #1;
      if (lat == 1) checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
      if (pulseBusy && (lat == 100 || lat == 1900)) begin
        start = 1'b1;
        key   = 24'hFFFFFF;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    if (!done) checkOutput("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic checkRun(input string tag, input logic [7:0] exp[MSG_LEN],
                          input int base, input int lat);
    int orderErrs;
    for (int n = 0; n < MSG_LEN; n++)
      checkOutput($sformatf("%s ct[%0d]", tag, n), {24'd0, ctram[n]}, {24'd0, exp[n]});
    checkOutput({tag, " ct_wren_count"}, ctAddrLog.size() - base, MSG_LEN);
    orderErrs = 0;
    for (int n = 0; n < MSG_LEN && base + n < ctAddrLog.size(); n++)
      if (ctAddrLog[base + n] != 5'(n)) orderErrs++;
    checkOutput({tag, " ct_addr_order_errs"}, orderErrs, 0);
    checkOutput({tag, " latency"}, lat, LATENCY);
    checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    string msg;
    int    lat, base, sBase, ctBase, wrongs, waited;
    logic [23:0] rk;
    bit    pulse;

    msg = "the quick brown fox jumps over ";
    for (int n = 0; n < MSG_LEN; n++) pt3[n] = (n < msg.len()) ? msg[n] : 8'h20;

    // Test 1: reset, then idle quietly.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset s_address", {24'd0, s_address}, 32'd0);
    checkOutput("reset ct_address", {27'd0, ct_address}, 32'd0);
    reset = 1'b0;
    sBase  = sWrTotal;
    ctBase = ctWrTotal;
    repeat (10) @(posedge clock);
    #1;
    checkOutput("idle busy", {31'd0, busy}, 32'd0);
    checkOutput("idle done", {31'd0, done}, 32'd0);
    checkOutput("idle s_wren pulses", sWrTotal - sBase, 0);
    checkOutput("idle ct_wren pulses", ctWrTotal - ctBase, 0);

    // Test 3: reference key and message.
    for (int n = 0; n < MSG_LEN; n++) ptram[n] = pt3[n];
    rc4Ref(24'h0003FF, pt3, ct3);
    base = ctAddrLog.size();
    applyStimulus(24'h0003FF, 1'b0, lat);
    checkRun("t3", ct3, base, lat);

    // Test 2: S-RAM holds a permutation now; INIT must rebuild the identity.
    startOnly(24'h000000);
    repeat (256) @(posedge clock);
    #1;
    wrongs = 0;
    for (int n = 0; n < 256; n++) if (sram[n] != 8'(n)) wrongs++;
    checkOutput("t2 init_identity_errs", wrongs, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("t2 abort busy", {31'd0, busy}, 32'd0);

    // Test 4: decrypting the ciphertext returns the plaintext.
    for (int n = 0; n < MSG_LEN; n++) ptram[n] = ctram[n];
    base = ctAddrLog.size();
    applyStimulus(24'h0003FF, 1'b0, lat);
    checkRun("t4", pt3, base, lat);

    // Test 5: start pulses while busy are ignored.
    for (int n = 0; n < MSG_LEN; n++) ptram[n] = pt3[n];
    base = ctAddrLog.size();
    applyStimulus(24'h0003FF, 1'b1, lat);
    checkRun("t5", ct3, base, lat);

    // Test 6: reset during the PRGA at k=10, then a clean rerun.
    base = ctAddrLog.size();
    startOnly(24'h0003FF);
    waited = 0;
    while (ctAddrLog.size() - base < 10 && waited < MAX_WAIT) begin
      @(posedge clock);
      #1;
      waited++;
    end
    checkOutput("t6 reached_k10", ctAddrLog.size() - base, 10);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("t6 busy", {31'd0, busy}, 32'd0);
    checkOutput("t6 done", {31'd0, done}, 32'd0);
    checkOutput("t6 s_wren", {31'd0, s_wren}, 32'd0);
    checkOutput("t6 ct_wren", {31'd0, ct_wren}, 32'd0);
    sBase  = sWrTotal;
    ctBase = ctWrTotal;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("t6 writes_after_reset", (sWrTotal - sBase) + (ctWrTotal - ctBase), 0);
    base = ctAddrLog.size();
    applyStimulus(24'h0003FF, 1'b0, lat);
    checkRun("t6", ct3, base, lat);

    // Randomised keys, messages and busy-time start pulses.
    for (int r = 0; r < 3; r++) begin
      rk    = 24'($urandom);
      pulse = 1'($urandom_range(0, 1));
      for (int n = 0; n < MSG_LEN; n++) ptram[n] = 8'($urandom);
      rc4Ref(rk, ptram, expCt);
      base = ctAddrLog.size();
      applyStimulus(rk, pulse, lat);
      checkRun($sformatf("rand%0d", r), expCt, base, lat);
    end

    checkOutput("wren_overlap_cycles", overlapTotal, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
